bitonic_stream_sorter: RTL and testbench

//  Streaming successor to the fully parallel bitonic sorter: accepts one element per cycle over

---
 rtl/bitonic_stream_sorter.sv | 199 +++++++++++++++++++
 tb/tb_bitonic_stream_sorter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_stream_sorter.sv
// Streaming bitonic sorter: loads a frame of up to N elements, sorts it in
// place with one reused column of N/2 compare-exchange units (one network
// stage per cycle), then drains the sorted frame over valid/ready.
module bitonic_stream_sorter #(
  parameter int LOG_INPUT  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  ascending,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int N = 1 << LOG_INPUT;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Pads sort to the tail: largest key for ascending, smallest for descending.
  localparam logic [DATA_WIDTH-1:0] PAD_MAX = (SIGNED != 0) ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                                            : {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] PAD_MIN = (SIGNED != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                            : {DATA_WIDTH{1'b0}};
  localparam logic [LOG_INPUT:0]    LAST_SLOT = {1'b0, {LOG_INPUT{1'b1}}};
  localparam logic [LOG_INPUT:0]    CNT_ONE   = (LOG_INPUT+1)'(1);
  localparam logic [LOG_INPUT:0]    P_FIRST   = (LOG_INPUT+1)'(2);
  localparam logic [LOG_INPUT-1:0]  Q_FIRST   = LOG_INPUT'(1);

  logic [1:0]            state_q, state_d;
  logic                  run_q;
  logic [LOG_INPUT:0]    cnt_q, cnt_d;
  logic [LOG_INPUT-1:0]  idx_q, idx_d;
  logic                  dir_q, dir_d;
  // Phase p and step q held one-hot: p_mask = 1<<p, q_mask = 1<<q.
  logic [LOG_INPUT:0]    p_mask_q, p_mask_d;
  logic [LOG_INPUT-1:0]  q_mask_q, q_mask_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic [DATA_WIDTH-1:0] buf_q [N];
  logic [DATA_WIDTH-1:0] net_d [N];

  logic                  load_fire;
  logic                  close;
  logic                  frame_dir;
  logic [LOG_INPUT-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0] pad;
  logic                  last_stage;
  logic [LOG_INPUT-1:0]  idx_inc;
  logic [LOG_INPUT:0]    last_idx;

  function automatic logic lt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) lt = $signed(a) < $signed(b);
    else             lt = a < b;
  endfunction

  assign in_ready  = (state_q == ST_LOAD) && run_q;
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign load_fire  = in_valid && in_ready;
  assign close      = load_fire && ((cnt_q == LAST_SLOT) || in_last);
  // The first beat's direction must already govern padding of a 1-element frame.
  assign frame_dir  = (cnt_q == '0) ? ascending : dir_q;
  assign wr_idx     = cnt_q[LOG_INPUT-1:0];
  assign pad        = frame_dir ? PAD_MAX : PAD_MIN;
  assign last_stage = (state_q == ST_SORT) && q_mask_q[0] && p_mask_q[LOG_INPUT];
  assign idx_inc    = idx_q + 1'b1;
  assign last_idx   = cnt_q - 1'b1;

  // One network stage: each element looks at its partner i^(1<<q) and keeps or takes its value.
  for (genvar gi = 0; gi < N; gi++) begin : g_cx
    localparam logic [LOG_INPUT:0] GI = (LOG_INPUT+1)'(gi);
    logic [LOG_INPUT-1:0]  partner;
    logic                  is_lower;
    logic                  pair_asc;
    logic                  swap;
    logic [DATA_WIDTH-1:0] own;
    logic [DATA_WIDTH-1:0] other;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;

    assign partner  = GI[LOG_INPUT-1:0] ^ q_mask_q;
    assign is_lower = ~|(GI[LOG_INPUT-1:0] & q_mask_q);
    // Bit p of the index flips the pair direction; bit LOG_INPUT is always 0.
    assign pair_asc = dir_q ^ (|(GI & p_mask_q));
    assign own      = buf_q[gi];
    assign other    = buf_q[partner];
    assign lo       = is_lower ? own : other;
    assign hi       = is_lower ? other : own;
    // Strict compare so equal keys never swap.
    assign swap     = pair_asc ? lt(hi, lo) : lt(lo, hi);
    assign net_d[gi] = swap ? other : own;
  end

  // Frame buffer: written by accepted beats (plus tail pads on close) and by each sort stage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (state_q == ST_SORT) begin
        buf_q[i] <= net_d[i];
      end else if (load_fire) begin
        if (wr_idx == i[LOG_INPUT-1:0]) buf_q[i] <= in_data;
        else if (close && (i[LOG_INPUT-1:0] > wr_idx)) buf_q[i] <= pad;
      end
    end
  end

  // Next-state logic for the LOAD -> SORT -> DRAIN sequencer and the output register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    p_mask_d   = p_mask_q;
    q_mask_d   = q_mask_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) dir_d = ascending;
          if (close) begin
            state_d  = ST_SORT;
            p_mask_d = P_FIRST;
            q_mask_d = Q_FIRST;
          end
        end
      end
      ST_SORT: begin
        if (last_stage) begin
          // Preload the first output straight from the final stage's result.
          state_d    = ST_DRAIN;
          idx_d      = '0;
          out_data_d = net_d[0];
          out_last_d = (cnt_q == CNT_ONE);
        end else if (q_mask_q[0]) begin
          p_mask_d = p_mask_q << 1;
          q_mask_d = p_mask_q[LOG_INPUT-1:0];
        end else begin
          q_mask_d = q_mask_q >> 1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = ST_LOAD;
            cnt_d      = '0;
            out_data_d = '0;
            out_last_d = 1'b0;
          end else begin
            idx_d      = idx_inc;
            out_data_d = buf_q[idx_inc];
            out_last_d = ({1'b0, idx_inc} == last_idx);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control registers with synchronous active-low reset; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      dir_q      <= 1'b1;
      p_mask_q   <= '0;
      q_mask_q   <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      p_mask_q   <= p_mask_d;
      q_mask_q   <= q_mask_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// Scoreboard bench for bitonic_stream_sorter: one unsigned and one signed
// instance (N=8) share stimulus; sel picks which one is driven and watched.
module tb_bitonic_stream_sorter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, ascending, out_ready, sel;
  logic [31:0] in_data;

  logic        in_ready_u, out_valid_u, out_last_u, busy_u;
  logic [31:0] out_data_u;
  logic        in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [31:0] out_data_s;

  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;

  assign in_ready  = sel ? in_ready_s  : in_ready_u;
  assign out_valid = sel ? out_valid_s : out_valid_u;
  assign out_last  = sel ? out_last_s  : out_last_u;
  assign busy      = sel ? busy_s      : busy_u;
  assign out_data  = sel ? out_data_s  : out_data_u;

  bitonic_stream_sorter #(.LOG_INPUT(3), .DATA_WIDTH(32), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .ascending(ascending),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_last(out_last_u), .busy(busy_u)
  );

  bitonic_stream_sorter #(.LOG_INPUT(3), .DATA_WIDTH(32), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .ascending(ascending),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_last(out_last_s), .busy(busy_s)
  );

  int          tests   = 0;
  int          fails   = 0;
  int          pop_cnt = 0;
  logic        rand_bp = 1'b0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Downstream ready: changes just after the rising edge so it is stable at the falling edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops expected output on every handshake, checks stall stability and in_ready.
  initial begin
    logic        stalled;
    logic [31:0] held_data;
    logic        held_last;
    logic [32:0] e;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        if (busy) check("in_ready_while_busy", in_ready, 0);
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, held_data);
          check("stall_last", out_last, held_last);
        end
        if (out_valid && out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            pop_cnt++;
            $display("[TB] out data=%h last=%b (exp %h/%b)", out_data, out_last, e[31:0], e[32]);
            check("out_data", out_data, e[31:0]);
            check("out_last", out_last, e[32]);
          end
        end else if (out_valid) begin
          stalled = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic send_frame(input int n, input logic asc, input logic use_last,
                            input logic [31:0] d[8], input logic [31:0] e[8]);
    int guard;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), e[i]});
    for (int i = 0; i < n; i++) begin
      guard = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d[i];
      in_last   = use_last && (i == n - 1);
      // Direction flips after the first beat; only the first beat's value may count.
      ascending = (i == 0) ? asc : ~asc;
      while (!in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        fail_now("in_ready_timeout");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && !busy && in_ready) && guard < 1000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (guard >= 1000) fail_now("idle_timeout");
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  logic [31:0] dv[8];
  logic [31:0] ev[8];
  int          base;
  int          g;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; ascending = 1'b1;
    in_data = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_u", in_ready_u, 0);
    check("rst_out_valid_u", out_valid_u, 0);
    check("rst_busy_u", busy_u, 0);
    check("rst_out_last_u", out_last_u, 0);
    check("rst_out_data_u", out_data_u, 0);
    check("rst_in_ready_s", in_ready_s, 0);
    check("rst_out_valid_s", out_valid_s, 0);
    check("rst_out_data_s", out_data_s, 0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Full ascending frame with latency check.
    dv = '{5, 3, 7, 1, 8, 2, 6, 4};
    ev = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_frame(8, 1'b1, 1'b0, dv, ev);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("sort_out_valid_low", out_valid, 0);
      check("sort_busy", busy, 1);
    end
    @(negedge clk);
    check("first_out_valid", out_valid, 1);
    wait_idle();

    // Short descending frame; pads must not appear.
    dv = '{9, 32'hFFFFFFFF, 4, 0, 0, 0, 0, 0};
    ev = '{32'hFFFFFFFF, 9, 4, 0, 0, 0, 0, 0};
    send_frame(3, 1'b0, 1'b1, dv, ev);
    wait_idle();

    // Signed instance.
    sel = 1'b1;
    dv = '{32'hFFFFFFFF, 5, 32'hFFFFFFF8, 0, 3, 32'hFFFFFFFD, 7, 2};
    ev = '{32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 2, 3, 5, 7};
    send_frame(8, 1'b1, 1'b0, dv, ev);
    dv = '{32'h7FFFFFFF, 32'hFFFFFFFE, 5, 0, 0, 0, 0, 0};
    ev = '{32'hFFFFFFFE, 5, 32'h7FFFFFFF, 0, 0, 0, 0, 0};
    send_frame(3, 1'b1, 1'b1, dv, ev);
    dv = '{32'h80000000, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
    ev = '{1, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 0, 0};
    send_frame(3, 1'b0, 1'b1, dv, ev);
    wait_idle();
    sel = 1'b0;

    // Backpressure with in_valid held high during SORT/DRAIN; in_last on the 8th beat.
    rand_bp = 1'b1;
    dv = '{10, 20, 30, 40, 50, 60, 70, 80};
    ev = '{80, 70, 60, 50, 40, 30, 20, 10};
    send_frame(8, 1'b0, 1'b1, dv, ev);
    in_valid = 1'b1;
    in_data  = 32'hBAD0BAD0;
    g = 0;
    while (g < 500) begin
      @(negedge clk);
      #1;
      g++;
      if (out_valid && out_last) break;
    end
    if (g >= 500) fail_now("drain_last_timeout");
    in_valid = 1'b0;
    wait_idle();
    rand_bp = 1'b0;

    // Reset in the middle of DRAIN after three outputs.
    @(negedge clk);
    base = pop_cnt;
    dv = '{15, 14, 13, 12, 11, 10, 9, 8};
    ev = '{8, 9, 10, 11, 12, 13, 14, 15};
    send_frame(8, 1'b1, 1'b0, dv, ev);
    g = 0;
    while (pop_cnt < base + 3 && g < 200) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (g >= 200) fail_now("reset_wait_timeout");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_data", out_data, 0);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_in_ready_after", in_ready, 1);
    dv = '{100, 3, 50, 3, 0, 0, 0, 0};
    ev = '{3, 3, 50, 100, 0, 0, 0, 0};
    send_frame(4, 1'b1, 1'b1, dv, ev);
    wait_idle();

    // Back-to-back frames, direction flipping, duplicates and 1-element frames.
    rand_bp = 1'b1;
    dv = '{4, 4, 1, 4, 2, 4, 1, 3};
    ev = '{1, 1, 2, 3, 4, 4, 4, 4};
    send_frame(8, 1'b1, 1'b0, dv, ev);
    dv = '{4, 4, 1, 4, 0, 0, 0, 0};
    ev = '{4, 4, 4, 1, 0, 0, 0, 0};
    send_frame(4, 1'b0, 1'b1, dv, ev);
    dv = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    ev = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1, 1'b1, 1'b1, dv, ev);
    dv = '{0, 0, 0, 0, 0, 0, 0, 0};
    ev = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1, 1'b0, 1'b1, dv, ev);
    dv = '{0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 7, 7, 0, 1};
    ev = '{32'hFFFFFFFF, 32'hFFFFFFFF, 7, 7, 1, 0, 0, 0};
    send_frame(8, 1'b0, 1'b0, dv, ev);
    wait_idle();
    rand_bp = 1'b0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
